// File: rtl/breakout_pkg.sv
// Shared types and constants for the breakout paddle path.
// Contents: paddle source and sequencer state enums, analog sample struct,
// default constants, and the analog-axis / position-resolve helpers.
package breakout_pkg;

    localparam int unsigned POS_W          = 8;
    localparam int unsigned DIG_INIT_DEF   = 114;
    localparam int unsigned DELTA_SLOW_DEF = 4;
    localparam int unsigned DELTA_FAST_DEF = 8;

    typedef enum logic [1:0] {
        SRC_DIG = 2'd0,
        SRC_X   = 2'd1,
        SRC_Y   = 2'd2,
        SRC_PAD = 2'd3
    } src_e;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } pad_state_e;

    // Analog stick sample: Y in the upper byte, X in the lower, both signed.
    typedef struct packed {
        logic signed [7:0] y;
        logic signed [7:0] x;
    } ana_t;

    // Signed axis to offset-binary (-128..127 -> 0..255).
    function automatic logic [POS_W-1:0] ana_map(input logic [7:0] s);
        return {~s[7], s[6:0]};
    endfunction

    // Select the raw position for a player; non-digital sources honour invert.
    function automatic logic [POS_W-1:0] resolve_pos(
        input src_e             src,
        input logic             inv,
        input ana_t             ana,
        input logic [POS_W-1:0] pad,
        input logic [POS_W-1:0] dig
    );
        logic [POS_W-1:0] raw;
        raw = dig;
        unique case (src)
            SRC_X:   raw = ana_map(ana.x);
            SRC_Y:   raw = ana_map(ana.y);
            SRC_PAD: raw = pad;
            default: raw = dig;
        endcase
        if (src == SRC_DIG) begin
            return dig;
        end
        return inv ? raw : ~raw;
    endfunction

endpackage

// File: rtl/paddle_digital_pos.sv
// Per-player digital paddle integrator.
// Ports: clk_sys/reset (sync, active-high); step_en qualifies one update;
// left/right buttons; delta step size; pos is the saturating 8-bit position.
module paddle_digital_pos
    import breakout_pkg::*;
#(
    parameter int unsigned DIG_INIT = DIG_INIT_DEF
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             step_en,
    input  logic             left,
    input  logic             right,
    input  logic [POS_W-1:0] delta,
    output logic [POS_W-1:0] pos
);

    logic [POS_W:0]   sum;
    logic [POS_W-1:0] pos_next;

    // One extra bit catches overflow on add and borrow on subtract.
    always_comb begin
        sum      = {1'b0, pos};
        pos_next = pos;
        if (step_en && (left ^ right)) begin
            if (left) begin
                sum      = {1'b0, pos} + {1'b0, delta};
                pos_next = sum[POS_W] ? '1 : sum[POS_W-1:0];
            end else begin
                sum      = {1'b0, pos} - {1'b0, delta};
                pos_next = sum[POS_W] ? '0 : sum[POS_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pos <= POS_W'(DIG_INIT);
        end else begin
            pos <= pos_next;
        end
    end

endmodule

// File: rtl/paddle_sequencer.sv
// Paddle position sequencer: resolves each player's position from digital,
// analog or paddle sources and emits a pulse whose length in hsync lines
// equals the active player's position once per paddle window.
// Ports: clk_sys, reset (sync, active-high); hsync/vsync/pad_en_n timing;
// player2/speed selects; per-player src/inv/buttons/analog/paddle inputs;
// pad_out comparator output; pos_p1/pos_p2 resolved positions.
module paddle_sequencer
    import breakout_pkg::*;
#(
    parameter int unsigned DIG_INIT   = DIG_INIT_DEF,
    parameter int unsigned DELTA_SLOW = DELTA_SLOW_DEF,
    parameter int unsigned DELTA_FAST = DELTA_FAST_DEF
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             pad_en_n,
    input  logic             player2,
    input  logic             speed,
    input  logic [1:0]       src_p1,
    input  logic [1:0]       src_p2,
    input  logic             inv_p1,
    input  logic             inv_p2,
    input  logic             left_p1,
    input  logic             right_p1,
    input  logic             left_p2,
    input  logic             right_p2,
    input  logic [15:0]      ana_p1,
    input  logic [15:0]      ana_p2,
    input  logic [POS_W-1:0] paddle_p1,
    input  logic [POS_W-1:0] paddle_p2,
    output logic             pad_out,
    output logic [POS_W-1:0] pos_p1,
    output logic [POS_W-1:0] pos_p2
);

    logic             hs_q;
    logic             vs_q;
    logic             hs_edge;
    logic             vs_edge;
    logic [POS_W-1:0] delta;
    logic [POS_W-1:0] dig_p1;
    logic [POS_W-1:0] dig_p2;

    pad_state_e       state;
    pad_state_e       state_next;
    logic [POS_W-1:0] counter;
    logic [POS_W-1:0] counter_next;
    logic [POS_W-1:0] target;
    logic [POS_W-1:0] target_next;
    logic             pad_out_next;

    assign hs_edge = hsync & ~hs_q;
    assign vs_edge = vsync & ~vs_q;
    assign delta   = speed ? POS_W'(DELTA_FAST) : POS_W'(DELTA_SLOW);

    // Only the player currently selected steps on a frame boundary.
    paddle_digital_pos #(.DIG_INIT(DIG_INIT)) u_dig_p1 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .step_en (vs_edge & ~player2),
        .left    (left_p1),
        .right   (right_p1),
        .delta   (delta),
        .pos     (dig_p1)
    );

    paddle_digital_pos #(.DIG_INIT(DIG_INIT)) u_dig_p2 (
        .clk_sys (clk_sys),
        .reset   (reset),
        .step_en (vs_edge & player2),
        .left    (left_p2),
        .right   (right_p2),
        .delta   (delta),
        .pos     (dig_p2)
    );

    // Window sequencer next-state; pad_out is the registered comparator.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        target_next  = target;
        pad_out_next = 1'b0;
        unique case (state)
            ARM: begin
                counter_next = '0;
                if (pad_en_n) begin
                    target_next = player2 ? pos_p2 : pos_p1;
                    state_next  = COUNT;
                end
            end
            COUNT: begin
                // Window close wins over a coincident hsync edge.
                if (!pad_en_n) begin
                    state_next   = ARM;
                    counter_next = '0;
                end else begin
                    pad_out_next = (counter < target);
                    if (counter >= target) begin
                        state_next = DONE;
                    end else if (hs_edge && (counter != '1)) begin
                        counter_next = counter + POS_W'(1);
                    end
                end
            end
            DONE: begin
                if (!pad_en_n) begin
                    state_next   = ARM;
                    counter_next = '0;
                end
            end
            default: begin
                state_next   = ARM;
                counter_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            state   <= ARM;
            counter <= '0;
            target  <= '0;
            pad_out <= 1'b0;
            pos_p1  <= POS_W'(DIG_INIT);
            pos_p2  <= POS_W'(DIG_INIT);
        end else begin
            hs_q    <= hsync;
            vs_q    <= vsync;
            state   <= state_next;
            counter <= counter_next;
            target  <= target_next;
            pad_out <= pad_out_next;
            pos_p1  <= resolve_pos(src_e'(src_p1), inv_p1, ana_t'(ana_p1), paddle_p1, dig_p1);
            pos_p2  <= resolve_pos(src_e'(src_p2), inv_p2, ana_t'(ana_p2), paddle_p2, dig_p2);
        end
    end

endmodule

// File: tb/tb_paddle_sequencer.sv
// Self-checking bench for paddle_sequencer: directed scenarios plus
// randomized routing and windows against a behavioural position model.
module tb_paddle_sequencer;

    localparam int DIG_INIT = 114;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        hsync;
    logic        vsync;
    logic        pad_en_n;
    logic        player2;
    logic        speed;
    logic [1:0]  src_p1;
    logic [1:0]  src_p2;
    logic        inv_p1;
    logic        inv_p2;
    logic        left_p1;
    logic        right_p1;
    logic        left_p2;
    logic        right_p2;
    logic [15:0] ana_p1;
    logic [15:0] ana_p2;
    logic [7:0]  paddle_p1;
    logic [7:0]  paddle_p2;
    logic        pad_out;
    logic [7:0]  pos_p1;
    logic [7:0]  pos_p2;

    int checks = 0;
    int errors = 0;
    int m_dig1 = DIG_INIT;
    int m_dig2 = DIG_INIT;

    always #5 clk_sys = ~clk_sys;

    paddle_sequencer dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .hsync     (hsync),
        .vsync     (vsync),
        .pad_en_n  (pad_en_n),
        .player2   (player2),
        .speed     (speed),
        .src_p1    (src_p1),
        .src_p2    (src_p2),
        .inv_p1    (inv_p1),
        .inv_p2    (inv_p2),
        .left_p1   (left_p1),
        .right_p1  (right_p1),
        .left_p2   (left_p2),
        .right_p2  (right_p2),
        .ana_p1    (ana_p1),
        .ana_p2    (ana_p2),
        .paddle_p1 (paddle_p1),
        .paddle_p2 (paddle_p2),
        .pad_out   (pad_out),
        .pos_p1    (pos_p1),
        .pos_p2    (pos_p2)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Position a player should show, from the source rules in plain arithmetic.
    function automatic int model_pos(input int src, input logic inv, input logic [15:0] ana,
                                     input logic [7:0] pad, input int dig);
        logic signed [7:0] sx;
        int a;
        sx = '0;
        if (src == 1) sx = ana[7:0];
        if (src == 2) sx = ana[15:8];
        if (src == 3) a = int'(pad);
        else          a = int'(sx) + 128;
        if (src == 0) return dig;
        return inv ? a : 255 - a;
    endfunction

    function automatic int model_target();
        if (player2) return model_pos(int'(src_p2), inv_p2, ana_p2, paddle_p2, m_dig2);
        return model_pos(int'(src_p1), inv_p1, ana_p1, paddle_p1, m_dig1);
    endfunction

    function automatic int step_dig(input int d, input logic l, input logic r, input int step);
        int n;
        n = d;
        if (l && !r) n = d + step;
        if (r && !l) n = d - step;
        if (n > 255) n = 255;
        if (n < 0)   n = 0;
        return n;
    endfunction

    // One frame: update the model, pulse vsync, then compare both positions.
    task automatic vsync_step(input string tag);
        int step;
        step = speed ? 8 : 4;
        if (!player2) m_dig1 = step_dig(m_dig1, left_p1, right_p1, step);
        else          m_dig2 = step_dig(m_dig2, left_p2, right_p2, step);
        vsync = 1'b1;
        tick();
        vsync = 1'b0;
        tick();
        check({tag, "_p1"}, pos_p1, 8'(model_pos(int'(src_p1), inv_p1, ana_p1, paddle_p1, m_dig1)));
        check({tag, "_p2"}, pos_p2, 8'(model_pos(int'(src_p2), inv_p2, ana_p2, paddle_p2, m_dig2)));
    endtask

    task automatic randomize_routing();
        player2   = 1'($urandom_range(0, 1));
        src_p1    = 2'($urandom_range(0, 3));
        src_p2    = 2'($urandom_range(0, 3));
        inv_p1    = 1'($urandom_range(0, 1));
        inv_p2    = 1'($urandom_range(0, 1));
        ana_p1    = 16'($urandom);
        ana_p2    = 16'($urandom);
        paddle_p1 = 8'($urandom);
        paddle_p2 = 8'($urandom);
        left_p1   = 1'($urandom_range(0, 1));
        right_p1  = 1'($urandom_range(0, 1));
        left_p2   = 1'($urandom_range(0, 1));
        right_p2  = 1'($urandom_range(0, 1));
        speed     = 1'($urandom_range(0, 1));
    endtask

    // Open a window and walk 256 hsync lines, comparing pad_out each line.
    // mut_kind: 1 = paddle_p1 to 0xC0, 2 = randomize routing, at line mut_at.
    // abort_kind: 1 = pad_en_n falls with an hsync edge, 2 = reset pulse, at line abort_at.
    task automatic run_window(input string tag, input int mut_kind, input int mut_at,
                              input int abort_kind, input int abort_at);
        int tgt;
        int highs;
        tick();
        tick();
        tgt   = model_target();
        highs = 0;
        pad_en_n = 1'b1;
        tick();
        tick();
        tick();
        for (int k = 0; k < 256; k++) begin
            if (abort_kind != 0 && k == abort_at) begin
                if (abort_kind == 1) begin
                    hsync    = 1'b1;
                    pad_en_n = 1'b0;
                    tick();
                    check({tag, "_close_now"}, 8'(pad_out), 8'd0);
                    hsync = 1'b0;
                    tick();
                    check({tag, "_close_after"}, 8'(pad_out), 8'd0);
                end else begin
                    reset    = 1'b1;
                    pad_en_n = 1'b0;
                    tick();
                    m_dig1 = DIG_INIT;
                    m_dig2 = DIG_INIT;
                    check({tag, "_rst_pad"}, 8'(pad_out), 8'd0);
                    check({tag, "_rst_pos"}, pos_p1, 8'(DIG_INIT));
                    reset = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        tick();
                        check({tag, "_rst_quiet"}, 8'(pad_out), 8'd0);
                    end
                end
                return;
            end
            check({tag, "_line"}, 8'(pad_out), (k < tgt) ? 8'd1 : 8'd0);
            if (pad_out === 1'b1) highs++;
            if (k == mut_at && mut_kind == 1) paddle_p1 = 8'hC0;
            if (k == mut_at && mut_kind == 2) randomize_routing();
            hsync = 1'b1;
            tick();
            hsync = 1'b0;
            tick();
            tick();
            tick();
        end
        check({tag, "_highs"}, 8'(highs), 8'(tgt));
        check({tag, "_tail"}, 8'(pad_out), 8'd0);
        pad_en_n = 1'b0;
        tick();
        tick();
        tick();
        check({tag, "_closed"}, 8'(pad_out), 8'd0);
    endtask

    initial begin
        reset     = 1'b1;
        hsync     = 1'b0;
        vsync     = 1'b0;
        pad_en_n  = 1'b0;
        player2   = 1'b0;
        speed     = 1'b0;
        src_p1    = 2'd0;
        src_p2    = 2'd0;
        inv_p1    = 1'b0;
        inv_p2    = 1'b0;
        left_p1   = 1'b0;
        right_p1  = 1'b0;
        left_p2   = 1'b0;
        right_p2  = 1'b0;
        ana_p1    = '0;
        ana_p2    = '0;
        paddle_p1 = '0;
        paddle_p2 = '0;
        tick();
        tick();
        check("rst_pad", 8'(pad_out), 8'd0);
        check("rst_p1", pos_p1, 8'd114);
        check("rst_p2", pos_p2, 8'd114);
        reset = 1'b0;
        tick();

        // Slow left steps, then saturation at the top.
        left_p1 = 1'b1;
        for (int i = 0; i < 20; i++) vsync_step("dig_up");
        check("dig_194", pos_p1, 8'd194);
        for (int i = 0; i < 40; i++) vsync_step("dig_up");
        check("dig_255", pos_p1, 8'd255);

        // Fast right steps down to the floor.
        left_p1  = 1'b0;
        right_p1 = 1'b1;
        speed    = 1'b1;
        for (int i = 0; i < 40; i++) vsync_step("dig_dn");
        check("dig_0", pos_p1, 8'd0);

        // Random buttons, speed and player select on digital sources.
        for (int i = 0; i < 40; i++) begin
            player2  = 1'($urandom_range(0, 1));
            speed    = 1'($urandom_range(0, 1));
            left_p1  = 1'($urandom_range(0, 1));
            right_p1 = 1'($urandom_range(0, 1));
            left_p2  = 1'($urandom_range(0, 1));
            right_p2 = 1'($urandom_range(0, 1));
            vsync_step("dig_rnd");
        end

        // Random routing of analog/paddle/digital sources with invert.
        for (int i = 0; i < 30; i++) begin
            randomize_routing();
            tick();
            tick();
            check("mux_p1", pos_p1, 8'(model_pos(int'(src_p1), inv_p1, ana_p1, paddle_p1, m_dig1)));
            check("mux_p2", pos_p2, 8'(model_pos(int'(src_p2), inv_p2, ana_p2, paddle_p2, m_dig2)));
        end

        // Fresh reset, walk p1 digital down to 10, then a 10-line window.
        left_p1 = 1'b0; right_p1 = 1'b0; left_p2 = 1'b0; right_p2 = 1'b0;
        src_p1 = 2'd0; src_p2 = 2'd0; player2 = 1'b0; speed = 1'b0;
        reset = 1'b1;
        tick();
        reset  = 1'b0;
        m_dig1 = DIG_INIT;
        m_dig2 = DIG_INIT;
        right_p1 = 1'b1;
        for (int i = 0; i < 26; i++) vsync_step("dig_to10");
        right_p1 = 1'b0;
        check("dig_10", pos_p1, 8'd10);
        run_window("win10", 0, 0, 0, 0);

        // Player 2 analog X at zero, both invert settings.
        player2 = 1'b1;
        src_p2  = 2'd1;
        inv_p2  = 1'b0;
        ana_p2  = 16'h0000;
        tick();
        tick();
        check("ana_7f", pos_p2, 8'h7F);
        run_window("win7f", 0, 0, 0, 0);
        inv_p2 = 1'b1;
        tick();
        tick();
        check("ana_80", pos_p2, 8'h80);
        run_window("win80", 0, 0, 0, 0);

        // Source change mid-window only affects the next window.
        player2   = 1'b0;
        src_p1    = 2'd3;
        inv_p1    = 1'b1;
        paddle_p1 = 8'h40;
        run_window("win40", 1, 20, 0, 0);
        run_window("winc0", 0, 0, 0, 0);

        // Target extremes.
        paddle_p1 = 8'd0;
        run_window("win0", 0, 0, 0, 0);
        paddle_p1 = 8'd255;
        run_window("win255", 0, 0, 0, 0);

        // Window close coincident with hsync, then a clean full window.
        paddle_p1 = 8'd100;
        run_window("close", 0, 0, 1, 30);
        run_window("after_close", 0, 0, 0, 0);

        // Reset mid-window, then a normal window.
        paddle_p1 = 8'd50;
        run_window("rst_mid", 0, 0, 2, 5);
        run_window("after_rst", 0, 0, 0, 0);

        // Random windows with inputs disturbed mid-count.
        for (int i = 0; i < 6; i++) begin
            randomize_routing();
            run_window("win_rnd", 2, $urandom_range(0, 255), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/paddle_sequencer.md
PADDLE_SEQUENCER -- requirements
Module: paddle_sequencer

Interface
REQ-001 SHALL have parameter DIG_INIT, default 114, the digital paddle position after reset.
REQ-002 SHALL have parameter DELTA_SLOW, default 4, the digital step per frame when speed=0.
REQ-003 SHALL have parameter DELTA_FAST, default 8, the digital step per frame when speed=1.
REQ-004 SHALL have port clk_sys, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port hsync, input, 1, the raw horizontal sync level from breakout_top.
REQ-007 SHALL have port vsync, input, 1, the raw vertical sync level from breakout_top.
REQ-008 SHALL have port pad_en_n, input, 1, the low-active paddle-window strobe from breakout_top.
REQ-009 SHALL have port player2, input, 1, which selects player 2's target when high.
REQ-010 SHALL have port speed, input, 1, which selects DELTA_FAST when high.
REQ-011 SHALL have ports src_p1 and src_p2, input, 2 each: 0=digital, 1=analog X, 2=analog Y, 3=paddle.
REQ-012 SHALL have ports inv_p1 and inv_p2, input, 1 each, the per-player invert selects.
REQ-013 SHALL have ports left_p1, right_p1, left_p2 and right_p2, input, 1 each, the digital buttons.
REQ-014 SHALL have ports ana_p1 and ana_p2, input, 16 each: [7:0]=X and [15:8]=Y, signed two's complement.
REQ-015 SHALL have ports paddle_p1 and paddle_p2, input, 8 each, unsigned paddle values.
REQ-016 SHALL have port pad_out, output, 1, the registered paddle comparator output to breakout_top.
REQ-017 SHALL have ports pos_p1 and pos_p2, output, 8 each, the registered resolved positions (debug/OSD).

Function
REQ-018 SHALL detect sync edges as edge = sig & ~sig_q, using one register stage per sync.
REQ-019 SHALL keep one 8-bit digital position per player and update it only on a vsync rising edge.
REQ-020 SHALL apply the digital update only to the active player (p1 when player2=0, p2 when player2=1).
REQ-021 SHALL add the step on left, subtract it on right, and hold the position when both or neither are pressed.
REQ-022 SHALL compute the digital update in 9 bits and saturate it to 0..255 (for example 2-4 gives 0 and 252+8 gives 255).
REQ-023 SHALL map an analog axis s as a = {~s[7], s[6:0]}.
REQ-024 SHALL resolve the position as inv ? a : ~a for analog sources, inv ? paddle : ~paddle for the paddle source, and the digital register for the digital source.
REQ-025 SHALL register pos_pN from the resolved position every cycle (1-cycle latency).
REQ-026 SHALL run an FSM with states ARM, COUNT and DONE.
REQ-027 In ARM, SHALL hold the line counter at 0 and pad_out at 0; on pad_en_n=1, SHALL latch target = (player2 ? pos_p2 : pos_p1) and go to COUNT.
REQ-028 In COUNT, SHALL increment the counter on each hsync rising edge, saturating at 255 with no wrap.
REQ-029 In COUNT, SHALL drive pad_out = (counter < target) and go to DONE when counter >= target.
REQ-030 In DONE, SHALL hold pad_out=0 and freeze the counter.
REQ-031 From COUNT or DONE, pad_out SHALL be 0 and the FSM SHALL go to ARM when pad_en_n=0; this has priority over an hsync edge in the same cycle.
REQ-032 Target=0 SHALL enter COUNT and move to DONE on the next cycle, so pad_out is never 1.
REQ-033 Changes to src, inv, player2 or the inputs during COUNT or DONE SHALL NOT affect the latched target until the next ARM.
REQ-034 pad_out SHALL be registered, 1 cycle after the state and counter update.

Reset
REQ-035 On reset=1, SHALL set the FSM to ARM, counter=0, target=0, pad_out=0, digital positions=DIG_INIT, pos_p1=pos_p2=DIG_INIT, and sync history=0.
REQ-036 Reset asserted mid-COUNT SHALL take effect on the next clock edge, with no partial pulse after it.

Structure
REQ-037 SHALL take the source enum (SRC_DIG, SRC_X, SRC_Y, SRC_PAD), the FSM state enum and the default constants from shared package breakout_pkg.
REQ-038 SHALL implement the per-player digital integrator (REQ-019 to REQ-022) as sub-module paddle_digital_pos, instantiated twice; the FSM and mux SHALL live in the top level.

Verification
REQ-039 SHALL verify: reset, then 20 vsync edges with left_p1=1, speed=0 and src_p1=0 -> pos_p1 = 114+80 = 194; 40 more edges -> 255 (saturates).
REQ-040 SHALL verify: src_p1=0, pos_p1=10, pad_en_n rises then 256 hsync edges -> pad_out high for exactly 10 hsync periods, then low until pad_en_n falls.
REQ-041 SHALL verify: src_p2=1, inv_p2=0, ana_p2[7:0]=0x00, player2=1 -> target 0x7F and 127 high periods; with inv_p2=1 -> target 0x80 and 128 high periods.
REQ-042 SHALL verify: src_p1 changed from paddle 0x40 to 0xC0 mid-COUNT -> the current window still ends at count 0x40 and the next window uses the new value.
REQ-043 SHALL verify: pad_en_n falls in the same cycle as an hsync edge during COUNT -> pad_out=0, FSM in ARM and counter=0 the next cycle.
REQ-044 SHALL verify: reset pulsed at count 5 of a target-50 window -> pad_out=0 and pos_p1=114 immediately; a normal window follows the next pad_en_n rise.
